// File: rtl/imem_responder.sv
// imem_responder: instruction-memory responder for the fetch stage.
// Accepts a fetch address, stalls fetch (enable_F=0) for LATENCY wait
// cycles, then presents a registered instruction for one cycle.
module imem_responder #(
  parameter int N       = 64,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N-1:0]             req_addr,
  input  logic                     req_valid,
  input  logic                     flush,
  output logic                     enable_F,
  output logic [31:0]              instr,
  output logic                     instr_valid,
  output logic                     fault,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [31:0]              wr_data,
  output logic [31:0]              served_count
);

  localparam int AW = $clog2(DEPTH);
  // DEPTH expressed at the width of the word-index field for the range check
  localparam logic [N-3:0] DEPTH_W = (N-2)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [31:0] data;
    logic        bad;
  } rsp_t;

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic [N-1:0] addr_q;
  logic        cap;
  logic        rsp_ld;
  rsp_t        rsp;

  logic [31:0] mem [DEPTH];

  // Access strobes: capture in IDLE, register the response on the last WAIT edge
  assign cap    = (state == IDLE) && req_valid && !flush;
  assign rsp_ld = (state == WAIT) && !flush && (cnt == 4'd0);

  // Lookup result; misaligned or out-of-range addresses return zero with a fault
  always_comb begin
    rsp.bad  = (addr_q[1:0] != 2'b00) || (addr_q[N-1:2] >= DEPTH_W);
    rsp.data = rsp.bad ? 32'h0 : mem[addr_q[AW+1:2]];
  end

  // Next-state and wait counter
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: if (cap) begin
        state_d = WAIT;
        cnt_d   = 4'(LATENCY - 1);
      end
      WAIT: begin
        if (flush)             state_d = IDLE;
        else if (cnt != 4'd0)  cnt_d   = cnt - 4'd1;
        else                   state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Fetch handshake outputs; enable_F held low while reset is asserted
  always_comb begin
    enable_F = 1'b0;
    case (state)
      IDLE:    enable_F = !req_valid || flush;
      WAIT:    enable_F = flush;
      RESP:    enable_F = 1'b1;
      default: enable_F = 1'b0;
    endcase
    enable_F    = enable_F && reset;
    instr_valid = (state == RESP) && !flush;
  end

  // State, counter and captured address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      addr_q <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (cap) addr_q <= req_addr;
    end
  end

  // Registered response; holds its value outside RESP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr <= 32'h0;
      fault <= 1'b0;
    end else if (rsp_ld) begin
      instr <= rsp.data;
      fault <= rsp.bad;
    end
  end

  // Delivered-response counter; a flush in RESP cancels delivery
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        served_count <= 32'd0;
    else if (state == RESP && !flush)  served_count <= served_count + 32'd1;
  end

  // Preload port; read in the same edge sees the old word
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule
